abacus_sample_controller: RTL and testbench

Sampling-window controller for the ABACUS profiler. It sequences the instruction and cache profiling units through clear → run → snapshot windows instead of leaving their enables under free software control. It drives the per-unit profiler enables, a counter-clear pulse and a snapshot pulse. It raises a sticky window-done interrupt and supports one-shot and periodic windows timed by a prescaled tick. It sits between the ABACUS register interface (Wishbone or AXI-Lite decode) and the profiler blocks.

---
 rtl/abacus_sample_controller_if.sv | 38 +++
 rtl/abacus_sample_controller.sv | 136 +++++++++++++
 tb/tb_abacus_sample_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/abacus_sample_controller_if.sv
// Purpose: register-side configuration strobes and profiler-side controls of the sampling controller.
// Latency: none, wires only.
// Backpressure: none; strobes are single-cycle and the controller never stalls the register interface.
interface abacus_sample_controller_if #(
    parameter int WINDOW_WIDTH   = 32,
    parameter int PRESCALE_WIDTH = 16
);
    logic                      cfg_start;
    logic                      cfg_stop;
    logic                      cfg_periodic;
    logic [1:0]                cfg_unit_mask;
    logic [WINDOW_WIDTH-1:0]   cfg_window_len;
    logic [PRESCALE_WIDTH-1:0] cfg_prescale;
    logic                      irq_ack;
    logic                      instr_profiler_enable;
    logic                      cache_profiler_enable;
    logic                      counter_clear;
    logic                      snapshot;
    logic                      window_done_irq;
    logic                      busy;
    logic [WINDOW_WIDTH-1:0]   window_count;

    // Register-interface side: issues configuration and strobes, observes status.
    modport master (
        output cfg_start, cfg_stop, cfg_periodic, cfg_unit_mask,
               cfg_window_len, cfg_prescale, irq_ack,
        input  instr_profiler_enable, cache_profiler_enable, counter_clear,
               snapshot, window_done_irq, busy, window_count
    );

    // Controller side.
    modport slave (
        input  cfg_start, cfg_stop, cfg_periodic, cfg_unit_mask,
               cfg_window_len, cfg_prescale, irq_ack,
        output instr_profiler_enable, cache_profiler_enable, counter_clear,
               snapshot, window_done_irq, busy, window_count
    );
endinterface

// File: rtl/abacus_sample_controller.sv
// Purpose: sequences profiler units through clear -> run -> snapshot windows timed by a prescaled tick.
// Latency: start at edge T gives clear in T+1, enables from T+2; all outputs decode from registered state.
// Backpressure: none; strobes arriving while busy are ignored, stop aborts from CLEAR/RUN only.
module abacus_sample_controller #(
    parameter int WINDOW_WIDTH   = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    abacus_sample_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEAR    = 2'd1,
        RUN      = 2'd2,
        SNAPSHOT = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic                      periodic_q, periodic_d;
    logic [1:0]                mask_q, mask_d;
    logic [WINDOW_WIDTH-1:0]   len_q, len_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] prescale_cnt_q, prescale_cnt_d;
    logic [WINDOW_WIDTH-1:0]   ticks_left_q, ticks_left_d;
    logic                      irq_q, irq_d;
    logic [WINDOW_WIDTH-1:0]   window_count_q, window_count_d;
    logic                      snap_entry;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: latched config, tick timing, irq and completed-window count.
    always_ff @(posedge clk) begin
        if (rst) begin
            periodic_q     <= 1'b0;
            mask_q         <= 2'b00;
            len_q          <= '0;
            prescale_q     <= '0;
            prescale_cnt_q <= '0;
            ticks_left_q   <= '0;
            irq_q          <= 1'b0;
            window_count_q <= '0;
        end else begin
            periodic_q     <= periodic_d;
            mask_q         <= mask_d;
            len_q          <= len_d;
            prescale_q     <= prescale_d;
            prescale_cnt_q <= prescale_cnt_d;
            ticks_left_q   <= ticks_left_d;
            irq_q          <= irq_d;
            window_count_q <= window_count_d;
        end
    end

    // Next-state and datapath update; config is only captured on the IDLE->CLEAR edge.
    always_comb begin
        state_d        = state_q;
        periodic_d     = periodic_q;
        mask_d         = mask_q;
        len_d          = len_q;
        prescale_d     = prescale_q;
        prescale_cnt_d = prescale_cnt_q;
        ticks_left_d   = ticks_left_q;
        snap_entry     = 1'b0;

        case (state_q)
            IDLE: begin
                // Stop wins over a simultaneous start.
                if (bus.cfg_start && !bus.cfg_stop) begin
                    state_d    = CLEAR;
                    periodic_d = bus.cfg_periodic;
                    mask_d     = bus.cfg_unit_mask;
                    len_d      = bus.cfg_window_len;
                    prescale_d = bus.cfg_prescale;
                end
            end
            CLEAR: begin
                if (bus.cfg_stop) begin
                    state_d = IDLE;
                end else begin
                    state_d        = RUN;
                    prescale_cnt_d = '0;
                    // A zero-length window still runs for one tick.
                    ticks_left_d   = (len_q == '0) ? WINDOW_WIDTH'(1) : len_q;
                end
            end
            RUN: begin
                if (bus.cfg_stop) begin
                    state_d = IDLE;
                end else if (prescale_cnt_q == prescale_q) begin
                    prescale_cnt_d = '0;
                    ticks_left_d   = ticks_left_q - WINDOW_WIDTH'(1);
                    if (ticks_left_q == WINDOW_WIDTH'(1)) begin
                        state_d    = SNAPSHOT;
                        snap_entry = 1'b1;
                    end
                end else begin
                    prescale_cnt_d = prescale_cnt_q + PRESCALE_WIDTH'(1);
                end
            end
            SNAPSHOT: begin
                // A stop here lets the window finish but prevents the next one.
                state_d = (periodic_q && !bus.cfg_stop) ? CLEAR : IDLE;
            end
            default: state_d = IDLE;
        endcase

        window_count_d = snap_entry ? (window_count_q + WINDOW_WIDTH'(1)) : window_count_q;

        // Set has priority over an acknowledge on the same edge.
        irq_d = irq_q;
        if (bus.irq_ack) begin
            irq_d = 1'b0;
        end
        if (snap_entry) begin
            irq_d = 1'b1;
        end
    end

    assign bus.counter_clear         = (state_q == CLEAR);
    assign bus.instr_profiler_enable = (state_q == RUN) && mask_q[0];
    assign bus.cache_profiler_enable = (state_q == RUN) && mask_q[1];
    assign bus.snapshot              = (state_q == SNAPSHOT);
    assign bus.busy                  = (state_q != IDLE);
    assign bus.window_done_irq       = irq_q;
    assign bus.window_count          = window_count_q;

endmodule

// File: tb/tb_abacus_sample_controller.sv
// Purpose: directed self-checking bench for the sampling-window controller.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_abacus_sample_controller;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    logic exp_irq;

    abacus_sample_controller_if #(.WINDOW_WIDTH(32), .PRESCALE_WIDTH(16)) bus ();

    abacus_sample_controller #(.WINDOW_WIDTH(32), .PRESCALE_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Packed view {instr_en, cache_en, clear, snapshot, irq, busy}.
    function automatic logic [5:0] outs();
        return {bus.instr_profiler_enable, bus.cache_profiler_enable, bus.counter_clear,
                bus.snapshot, bus.window_done_irq, bus.busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic per, input logic [1:0] mask,
                           input logic [31:0] len, input logic [15:0] pre);
        bus.cfg_periodic   = per;
        bus.cfg_unit_mask  = mask;
        bus.cfg_window_len = len;
        bus.cfg_prescale   = pre;
    endtask

    task automatic start_pulse();
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    // One-shot len=4 prescale=0 both units, starting from idle with irq clear.
    task automatic oneshot4(input string tag);
        set_cfg(1'b0, 2'b11, 32'd4, 16'd0);
        start_pulse();
        check({tag, "_clear"}, 32'(outs()), 32'(6'b001001));
        for (int i = 0; i < 4; i++) begin
            tick();
            check({tag, "_run"}, 32'(outs()), 32'(6'b110001));
        end
        tick();
        exp_cnt++;
        check({tag, "_snap"}, 32'(outs()), 32'(6'b000111));
        check({tag, "_cnt"}, bus.window_count, exp_cnt);
        tick();
        check({tag, "_idle"}, 32'(outs()), 32'(6'b000010));
    endtask

    initial begin
        rst             = 1'b1;
        bus.cfg_start   = 1'b0;
        bus.cfg_stop    = 1'b0;
        bus.irq_ack     = 1'b0;
        set_cfg(1'b0, 2'b00, 32'd0, 16'd0);
        tick();
        tick();
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_cnt", bus.window_count, 32'd0);
        rst = 1'b0;
        tick();

        // Basic one-shot window.
        oneshot4("os");
        ack_pulse();
        check("ack_clear", 32'(outs()), 32'd0);

        // Zero-length window runs one cycle.
        set_cfg(1'b0, 2'b11, 32'd0, 16'd0);
        start_pulse();
        check("len0_clear", 32'(outs()), 32'(6'b001001));
        tick();
        check("len0_run", 32'(outs()), 32'(6'b110001));
        tick();
        exp_cnt++;
        check("len0_snap", 32'(outs()), 32'(6'b000111));
        check("len0_cnt", bus.window_count, exp_cnt);
        tick();
        check("len0_idle", 32'(outs()), 32'(6'b000010));
        ack_pulse();

        // Start and stop together: stays idle.
        bus.cfg_start = 1'b1;
        bus.cfg_stop  = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        bus.cfg_stop  = 1'b0;
        check("startstop_idle", 32'(outs()), 32'd0);
        tick();
        check("startstop_idle2", 32'(outs()), 32'd0);

        // Start while running and config change mid-run are ignored.
        set_cfg(1'b0, 2'b10, 32'd3, 16'd0);
        start_pulse();
        check("midcfg_clear", 32'(outs()), 32'(6'b001001));
        tick();
        check("midcfg_run0", 32'(outs()), 32'(6'b010001));
        set_cfg(1'b1, 2'b01, 32'd10, 16'd5);
        start_pulse();
        check("midcfg_run1", 32'(outs()), 32'(6'b010001));
        tick();
        check("midcfg_run2", 32'(outs()), 32'(6'b010001));
        tick();
        exp_cnt++;
        check("midcfg_snap", 32'(outs()), 32'(6'b000111));
        check("midcfg_cnt", bus.window_count, exp_cnt);
        tick();
        check("midcfg_idle", 32'(outs()), 32'(6'b000010));
        ack_pulse();

        // Periodic windows, instruction unit only, then stop during RUN.
        set_cfg(1'b1, 2'b01, 32'd2, 16'd2);
        start_pulse();
        exp_irq = 1'b0;
        for (int w = 0; w < 3; w++) begin
            check("per_clear", 32'(outs()), 32'({4'b0010, exp_irq, 1'b1}));
            for (int c = 0; c < 6; c++) begin
                tick();
                check("per_run", 32'(outs()), 32'({4'b1000, exp_irq, 1'b1}));
            end
            tick();
            exp_cnt++;
            exp_irq = 1'b1;
            check("per_snap", 32'(outs()), 32'(6'b000111));
            check("per_cnt", bus.window_count, exp_cnt);
            tick();
        end
        check("per_clear4", 32'(outs()), 32'(6'b001011));
        tick();
        tick();
        check("per_run4", 32'(outs()), 32'(6'b100011));
        bus.cfg_stop = 1'b1;
        tick();
        bus.cfg_stop = 1'b0;
        check("per_stop", 32'(outs()), 32'(6'b000010));
        check("per_stop_cnt", bus.window_count, exp_cnt);
        ack_pulse();

        // Ack on the same edge as snapshot entry: set wins.
        set_cfg(1'b0, 2'b11, 32'd1, 16'd0);
        start_pulse();
        tick();
        check("race_run", 32'(outs()), 32'(6'b110001));
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        exp_cnt++;
        check("race_snap", 32'(outs()), 32'(6'b000111));
        tick();
        check("race_idle", 32'(outs()), 32'(6'b000010));
        ack_pulse();
        check("race_ack", 32'(outs()), 32'd0);

        // Stop during SNAPSHOT in periodic mode: window completes, then idle.
        set_cfg(1'b1, 2'b11, 32'd1, 16'd0);
        start_pulse();
        tick();
        tick();
        exp_cnt++;
        check("snapstop_snap", 32'(outs()), 32'(6'b000111));
        bus.cfg_stop = 1'b1;
        tick();
        bus.cfg_stop = 1'b0;
        check("snapstop_idle", 32'(outs()), 32'(6'b000010));
        check("snapstop_cnt", bus.window_count, exp_cnt);
        tick();
        check("snapstop_idle2", 32'(outs()), 32'(6'b000010));
        ack_pulse();

        // Reset mid-run, then the first scenario again from scratch.
        set_cfg(1'b0, 2'b11, 32'd4, 16'd0);
        start_pulse();
        tick();
        tick();
        check("rst_pre", 32'(outs()), 32'(6'b110001));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        check("rst_outs", 32'(outs()), 32'd0);
        check("rst_cnt", bus.window_count, 32'd0);
        oneshot4("rr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
